// File: rtl/instrumented_adder_pkg.sv
// Shared types and constants for the instrumented adder measurement block.
package instrumented_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_LOOP = 1'b1;

endpackage

// File: rtl/adder_core.sv
// Combinational Brent-Kung prefix adder; carry-in is zero, carry-out on sum[WIDTH].
module adder_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  localparam int unsigned TOP = (WIDTH > 2) ? (1 << ($clog2(WIDTH) - 1)) : 1;

  // Prefix tree is built on local variables so no signal feeds back on itself.
  function automatic logic [WIDTH:0] bk_add(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    g = x & y;
    p = x ^ y;
    h = p;
    for (int d = 1; d < int'(WIDTH); d = d * 2) begin
      for (int i = 2 * d - 1; i < int'(WIDTH); i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = int'(TOP); d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < int'(WIDTH); i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    return {g[WIDTH-1], h ^ {g[WIDTH-2:0], 1'b0}};
  endfunction

  assign {carry_c, sum_c} = bk_add(a, b);

endmodule

// File: rtl/instrumented_adder_meas.sv
// Adder with a self-oscillating feedback loop: one sum bit is inverted back into
// an operand bit and its toggles are counted over a programmable window.
module instrumented_adder_meas
  import instrumented_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             active,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [SEL_W-1:0] ring_sel,
  input  logic [SEL_W-1:0] tap_sel,
  input  logic [CNT_W-1:0] window,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W:0] W_LIM = (SEL_W + 1)'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [SEL_W-1:0] ring_r;
  logic [SEL_W-1:0] tap_r;
  logic [CNT_W-1:0] win_r;
  logic [CNT_W-1:0] cyc_cnt;
  logic             mode_r;

  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic [SEL_W-1:0] ring_idx;
  logic [SEL_W-1:0] tap_idx;
  logic             fb_c;

  adder_core #(.WIDTH(WIDTH)) u_adder (
    .a      (a_reg),
    .b      (b_reg),
    .sum_c  (sum_c),
    .carry_c(carry_c)
  );

  // Out-of-range selects fall back to bit 0.
  assign ring_idx = ({1'b0, ring_r} < W_LIM) ? ring_r : '0;
  assign tap_idx  = ({1'b0, tap_r} < W_LIM) ? tap_r : '0;
  assign fb_c     = ~sum_c[tap_idx];

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      ring_r    <= '0;
      tap_r     <= '0;
      win_r     <= '0;
      cyc_cnt   <= '0;
      mode_r    <= MODE_ADD;
      sum_out   <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && active) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            ring_r <= ring_sel;
            tap_r  <= tap_sel;
            win_r  <= window;
            mode_r <= mode;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (!active) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            sum_out   <= sum_c;
            carry_out <= carry_c;
            if (mode_r == MODE_ADD || win_r == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              cyc_cnt <= win_r;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!active) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            sum_out         <= sum_c;
            carry_out       <= carry_c;
            a_reg[ring_idx] <= fb_c;
            if (a_reg[ring_idx] != fb_c && count != '1) begin
              count <= count + CNT_W'(1);
            end
            cyc_cnt <= cyc_cnt - CNT_W'(1);
            if (cyc_cnt == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrumented_adder_meas.sv
// Randomized and directed checks of instrumented_adder_meas against a behavioural loop model.
module tb_instrumented_adder_meas;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned SEL_W = 5;

  logic             wb_clk_i = 1'b0;
  logic             reset_n  = 1'b0;
  logic             active   = 1'b0;
  logic             start    = 1'b0;
  logic             mode     = 1'b0;
  logic [WIDTH-1:0] a_in     = '0;
  logic [WIDTH-1:0] b_in     = '0;
  logic [SEL_W-1:0] ring_sel = '0;
  logic [SEL_W-1:0] tap_sel  = '0;
  logic [CNT_W-1:0] window   = '0;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  instrumented_adder_meas #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .wb_clk_i (wb_clk_i),
    .reset_n  (reset_n),
    .active   (active),
    .start    (start),
    .mode     (mode),
    .a_in     (a_in),
    .b_in     (b_in),
    .ring_sel (ring_sel),
    .tap_sel  (tap_sel),
    .window   (window),
    .sum_out  (sum_out),
    .carry_out(carry_out),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Loop model: each loop cycle the operand bit takes the inverse of the tapped sum bit.
  task automatic ref_model(input bit m, input logic [31:0] a, input logic [31:0] b,
                           input int r, input int t, input int unsigned iters,
                           output logic [31:0] s, output bit c, output longint unsigned cnt);
    logic [32:0] full;
    logic        nb;
    int          rr;
    int          tt;
    rr   = (r >= 32) ? 0 : r;
    tt   = (t >= 32) ? 0 : t;
    full = {1'b0, a} + {1'b0, b};
    cnt  = 0;
    if (m) begin
      for (int unsigned k = 0; k < iters; k++) begin
        full = {1'b0, a} + {1'b0, b};
        nb   = ~full[tt];
        if (a[rr] != nb) cnt++;
        a[rr] = nb;
      end
    end
    s = full[31:0];
    c = full[32];
  endtask

  task automatic run_txn(input bit m, input logic [31:0] a, input logic [31:0] b,
                         input int r, input int t, input int unsigned win, input bit poke);
    logic [31:0]     es;
    bit              ec;
    longint unsigned en;
    int              n;
    int              exp_lat;
    ref_model(m, a, b, r, t, win, es, ec, en);
    exp_lat  = (!m || win == 0) ? 2 : int'(win) + 2;
    mode     = m;
    a_in     = a;
    b_in     = b;
    ring_sel = SEL_W'(r);
    tap_sel  = SEL_W'(t);
    window   = win;
    start    = 1'b1;
    step();
    start    = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    window   = CNT_W'($urandom_range(0, 7));
    mode     = ~m;
    check("busy_arm", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < int'(win) + 10) begin
      start = (poke && n == 3);
      step();
      n++;
    end
    start = 1'b0;
    check("done_latency", 64'(n), 64'(exp_lat));
    check("sum_out", 64'(sum_out), 64'(es));
    check("carry_out", 64'(carry_out), 64'(ec));
    check("count", 64'(count), 64'(en));
    check("busy_done", 64'(busy), 64'd0);
    step();
    check("done_width", 64'(done), 64'd0);
    step();
    step();
    check("sum_hold", 64'(sum_out), 64'(es));
    check("count_hold", 64'(count), 64'(en));
  endtask

  initial begin
    logic [31:0]     es;
    bit              ec;
    longint unsigned en;
    logic [31:0]     ra;
    logic [31:0]     rb;
    int              rr;
    int              rt;
    bit              seen;

    step();
    step();
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    active  = 1'b1;
    step();

    run_txn(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h0, 32'h0, 7, 7, 10, 1'b0);
    run_txn(1'b1, 32'h0, 32'h0, 7, 0, 10, 1'b1);

    for (int i = 0; i < 30; i++) begin
      bit          m;
      int unsigned w;
      m = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 24);
      run_txn(m, $urandom, $urandom, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), w, m && w >= 2);
    end

    // Abort: active falls in the fifth RUN cycle, so four loop updates have landed.
    ra = $urandom;
    rb = $urandom;
    rr = int'($urandom_range(0, 31));
    rt = int'($urandom_range(0, 31));
    ref_model(1'b1, ra, rb, rr, rt, 4, es, ec, en);
    mode = 1'b1; a_in = ra; b_in = rb;
    ring_sel = SEL_W'(rr); tap_sel = SEL_W'(rt); window = CNT_W'(100);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    mode = 1'b0; a_in = ~ra; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("abort_busy_run", 64'(busy), 64'd1);
    active = 1'b0;
    step();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum_out), 64'(es));
    check("abort_carry", 64'(carry_out), 64'(ec));
    check("abort_count", 64'(count), 64'(en));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= done;
      step();
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hold_count", 64'(count), 64'(en));
    active = 1'b1;
    step();

    // Reset mid-RUN clears everything at once and leaves no done behind.
    mode = 1'b1; a_in = $urandom; b_in = $urandom;
    ring_sel = 5'd3; tap_sel = 5'd3; window = CNT_W'(50);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #3 reset_n = 1'b0;
    #1;
    check("mrst_sum", 64'(sum_out), 64'd0);
    check("mrst_carry", 64'(carry_out), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= done | busy;
      step();
    end
    check("mrst_no_done", 64'(seen), 64'd0);

    run_txn(1'b1, $urandom, $urandom, 5, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
